// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path: renderer-facing game_state
// codes, sequencer state encodings and game defaults.
package pong_pkg;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_WIN1 = 2'b10;
    localparam logic [1:0] GS_WIN2 = 2'b11;

    localparam int DEFAULT_WIN_SCORE = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN1  = 3'd3,
        ST_WIN2  = 3'd4
    } state_t;

    function automatic logic [1:0] state_to_gs(input state_t st);
        case (st)
            ST_SERVE, ST_PLAY: return GS_PLAY;
            ST_WIN1:           return GS_WIN1;
            ST_WIN2:           return GS_WIN2;
            default:           return GS_IDLE;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_state_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector; o_edge is a one-cycle pulse three clocks after the press.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_meta   <= i_btn;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_edge   <= r_sync & ~r_sync_d;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/game_state_ctrl.sv
// Pong game sequencer: scores, serve delay, win-screen hold, and the
// frame-aligned game_state bus consumed by the renderer.
module game_state_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = DEFAULT_WIN_SCORE,
    parameter int SERVE_DELAY_MS = 1000,
    parameter int WIN_HOLD_MS    = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] game_state,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       serve_dir
);

    // Floor of 2 keeps the timer at least one bit wide for tiny delays.
    localparam int TIMER_W = $clog2(max_int(max_int(SERVE_DELAY_MS, WIN_HOLD_MS), 2));

    localparam logic [TIMER_W-1:0] SERVE_LAST  = TIMER_W'(SERVE_DELAY_MS - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST    = TIMER_W'(WIN_HOLD_MS - 1);
    localparam logic [3:0]         WIN_SCORE_V = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_SCORE_V) ? WIN_SCORE_V : s + 4'd1;
    endfunction

    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_score1;
    logic [3:0]         r_score2;
    logic               r_ball_enable;
    logic               r_ball_reset;
    logic               r_serve_dir;
    logic [1:0]         r_game_state;

    state_t             w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [3:0]         w_score1_nxt;
    logic [3:0]         w_score2_nxt;
    logic               w_ball_enable_nxt;
    logic               w_ball_reset_nxt;
    logic               w_serve_dir_nxt;
    logic               w_start_edge;

    btn_sync_edge u_start_sync (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (start_btn),
        .o_edge (w_start_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_score1      <= 4'd0;
            r_score2      <= 4'd0;
            r_ball_enable <= 1'b0;
            r_ball_reset  <= 1'b0;
            r_serve_dir   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_score1      <= w_score1_nxt;
            r_score2      <= w_score2_nxt;
            r_ball_enable <= w_ball_enable_nxt;
            r_ball_reset  <= w_ball_reset_nxt;
            r_serve_dir   <= w_serve_dir_nxt;
        end
    end

    // Published only at frame boundaries, from the pre-transition state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_game_state <= GS_IDLE;
        end else if (frame_start) begin
            r_game_state <= state_to_gs(r_state);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_score1_nxt     = r_score1;
        w_score2_nxt     = r_score2;
        w_ball_reset_nxt = 1'b0;
        w_serve_dir_nxt  = r_serve_dir;

        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_score1_nxt     = 4'd0;
                    w_score2_nxt     = 4'd0;
                    w_serve_dir_nxt  = 1'b0;
                    w_timer_nxt      = '0;
                    w_ball_reset_nxt = 1'b1;
                    w_state_nxt      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick_1ms) begin
                    if (r_timer == SERVE_LAST) begin
                        w_timer_nxt = '0;
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // A simultaneous double miss replays the point with no score change.
                if (miss_left && miss_right) begin
                    w_timer_nxt      = '0;
                    w_ball_reset_nxt = 1'b1;
                    w_state_nxt      = ST_SERVE;
                end else if (miss_right) begin
                    w_score1_nxt = sat_inc(r_score1);
                    w_timer_nxt  = '0;
                    if (sat_inc(r_score1) == WIN_SCORE_V) begin
                        w_state_nxt = ST_WIN1;
                    end else begin
                        w_serve_dir_nxt  = 1'b1;
                        w_ball_reset_nxt = 1'b1;
                        w_state_nxt      = ST_SERVE;
                    end
                end else if (miss_left) begin
                    w_score2_nxt = sat_inc(r_score2);
                    w_timer_nxt  = '0;
                    if (sat_inc(r_score2) == WIN_SCORE_V) begin
                        w_state_nxt = ST_WIN2;
                    end else begin
                        w_serve_dir_nxt  = 1'b0;
                        w_ball_reset_nxt = 1'b1;
                        w_state_nxt      = ST_SERVE;
                    end
                end
            end
            ST_WIN1, ST_WIN2: begin
                if (tick_1ms) begin
                    if (r_timer == WIN_LAST) begin
                        w_timer_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_ball_enable_nxt = (w_state_nxt == ST_PLAY);
    end

    assign game_state  = r_game_state;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign ball_enable = r_ball_enable;
    assign ball_reset  = r_ball_reset;
    assign serve_dir   = r_serve_dir;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters (win at 5,
// 1000-tick serve delay, 3000-tick win hold).
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1ms;
    logic       frame_start;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] game_state;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1ms    (tick_1ms),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .game_state  (game_state),
        .score1      (score1),
        .score2      (score2),
        .ball_enable (ball_enable),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir)
    );

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1;
            @(negedge clk);
            tick_1ms = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        @(negedge clk);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        repeat (5) @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL rst_game_state: got %b expected 00", game_state); end
        checks++; if (score1 !== 4'd0) begin errors++; $display("FAIL rst_score1: got %0d expected 0", score1); end
        checks++; if (score2 !== 4'd0) begin errors++; $display("FAIL rst_score2: got %0d expected 0", score2); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL rst_ball_enable: got %b expected 0", ball_enable); end
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL rst_ball_reset: got %b expected 0", ball_reset); end
        checks++; if (serve_dir !== 1'b0) begin errors++; $display("FAIL rst_serve_dir: got %b expected 0", serve_dir); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL start_early_ball_reset: got %b expected 0", ball_reset); end
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL start_gs_before_frame: got %b expected 00", game_state); end
        @(negedge clk);
        checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL start_ball_reset_pulse: got %b expected 1", ball_reset); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL start_ball_enable: got %b expected 0", ball_enable); end
        @(negedge clk);
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL start_ball_reset_width: got %b expected 0", ball_reset); end
        start_btn = 1'b0;
        frame();
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL start_gs_frame: got %b expected 01", game_state); end
        ticks(999);
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL start_enable_999: got %b expected 0", ball_enable); end
        ticks(1);
        checks++; if (ball_enable !== 1'b1) begin errors++; $display("FAIL start_enable_1000: got %b expected 1", ball_enable); end
    endtask

    task automatic test_miss_right();
        miss(1'b0, 1'b1);
        checks++; if (score1 !== 4'd1) begin errors++; $display("FAIL mr_score1: got %0d expected 1", score1); end
        checks++; if (score2 !== 4'd0) begin errors++; $display("FAIL mr_score2: got %0d expected 0", score2); end
        checks++; if (serve_dir !== 1'b1) begin errors++; $display("FAIL mr_serve_dir: got %b expected 1", serve_dir); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL mr_ball_enable: got %b expected 0", ball_enable); end
        checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL mr_ball_reset: got %b expected 1", ball_reset); end
        @(negedge clk);
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL mr_ball_reset_width: got %b expected 0", ball_reset); end
        ticks(1000);
        checks++; if (ball_enable !== 1'b1) begin errors++; $display("FAIL mr_reserve_enable: got %b expected 1", ball_enable); end
    endtask

    task automatic test_double_miss();
        miss(1'b1, 1'b1);
        checks++; if (score1 !== 4'd1) begin errors++; $display("FAIL dm_score1: got %0d expected 1", score1); end
        checks++; if (score2 !== 4'd0) begin errors++; $display("FAIL dm_score2: got %0d expected 0", score2); end
        checks++; if (serve_dir !== 1'b1) begin errors++; $display("FAIL dm_serve_dir: got %b expected 1", serve_dir); end
        checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL dm_ball_reset: got %b expected 1", ball_reset); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL dm_ball_enable: got %b expected 0", ball_enable); end
        ticks(1000);
        checks++; if (ball_enable !== 1'b1) begin errors++; $display("FAIL dm_reserve_enable: got %b expected 1", ball_enable); end
    endtask

    task automatic test_win2();
        for (int i = 0; i < 4; i++) begin
            miss(1'b1, 1'b0);
            ticks(1000);
        end
        checks++; if (score2 !== 4'd4) begin errors++; $display("FAIL w2_score2_pre: got %0d expected 4", score2); end
        checks++; if (serve_dir !== 1'b0) begin errors++; $display("FAIL w2_serve_dir: got %b expected 0", serve_dir); end
        frame();
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL w2_gs_play: got %b expected 01", game_state); end
        miss(1'b1, 1'b0);
        checks++; if (score2 !== 4'd5) begin errors++; $display("FAIL w2_score2_win: got %0d expected 5", score2); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL w2_ball_enable: got %b expected 0", ball_enable); end
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL w2_no_ball_reset: got %b expected 0", ball_reset); end
        repeat (2) @(negedge clk);
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL w2_gs_held: got %b expected 01", game_state); end
        frame();
        checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL w2_gs_win: got %b expected 11", game_state); end
        miss(1'b0, 1'b1);
        miss(1'b1, 1'b0);
        start_btn = 1'b1;
        repeat (6) @(negedge clk);
        start_btn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (score1 !== 4'd1) begin errors++; $display("FAIL w2_frozen_score1: got %0d expected 1", score1); end
        checks++; if (score2 !== 4'd5) begin errors++; $display("FAIL w2_frozen_score2: got %0d expected 5", score2); end
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL w2_start_ignored: got %b expected 0", ball_reset); end
        ticks(2999);
        frame();
        checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL w2_hold_2999: got %b expected 11", game_state); end
        ticks(1);
        frame();
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL w2_idle_3000: got %b expected 00", game_state); end
        checks++; if (score2 !== 4'd5) begin errors++; $display("FAIL w2_idle_score2: got %0d expected 5", score2); end
    endtask

    task automatic test_frame_hold();
        press_start();
        checks++; if (score1 !== 4'd0 || score2 !== 4'd0) begin errors++; $display("FAIL fh_scores_cleared: got %0d/%0d expected 0/0", score1, score2); end
        ticks(1000);
        frame();
        for (int i = 0; i < 4; i++) begin
            miss(1'b0, 1'b1);
            ticks(1000);
        end
        checks++; if (score1 !== 4'd4) begin errors++; $display("FAIL fh_score1_pre: got %0d expected 4", score1); end
        // Frame pulse coincides with the winning miss: bus must keep the PLAY code.
        frame_start = 1'b1;
        miss(1'b0, 1'b1);
        frame_start = 1'b0;
        checks++; if (score1 !== 4'd5) begin errors++; $display("FAIL fh_score1_win: got %0d expected 5", score1); end
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL fh_gs_same_cycle: got %b expected 01", game_state); end
        repeat (3) @(negedge clk);
        checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL fh_gs_no_frame: got %b expected 01", game_state); end
        frame();
        checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL fh_gs_win1: got %b expected 10", game_state); end
    endtask

    task automatic test_async_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        press_start();
        ticks(1000);
        for (int i = 0; i < 3; i++) begin
            miss(1'b0, 1'b1);
            ticks(1000);
        end
        frame();
        checks++; if (score1 !== 4'd3) begin errors++; $display("FAIL ar_score1_pre: got %0d expected 3", score1); end
        checks++; if (ball_enable !== 1'b1) begin errors++; $display("FAIL ar_enable_pre: got %b expected 1", ball_enable); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL ar_game_state: got %b expected 00", game_state); end
        checks++; if (score1 !== 4'd0) begin errors++; $display("FAIL ar_score1: got %0d expected 0", score1); end
        checks++; if (ball_enable !== 1'b0) begin errors++; $display("FAIL ar_ball_enable: got %b expected 0", ball_enable); end
        checks++; if (serve_dir !== 1'b0) begin errors++; $display("FAIL ar_serve_dir: got %b expected 0", serve_dir); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        tick_1ms    = 1'b0;
        frame_start = 1'b0;
        start_btn   = 1'b0;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
        test_reset();
        test_start();
        test_miss_right();
        test_double_miss();
        test_win2();
        test_frame_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
